// File: rtl/seq_detect_multi_if.sv
// seq_detect_multi_if: serial data, runtime configuration and result signals
// of the multi-pattern detector. The master side drives the bit stream and
// the configuration. The slave side is the detector.
// With SEQ_DET_STICKY_EN defined, a per-slot sticky vector is added.
interface seq_detect_multi_if #(
  parameter int N_PAT   = 2,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic                     din;
  logic                     din_valid;
  logic                     cfg_load;
  logic [N_PAT*MAX_LEN-1:0] pat_cfg;
  logic [N_PAT*LW-1:0]      len_cfg;
  logic [N_PAT-1:0]         overlap_en;
  logic                     cnt_clr;
  logic [N_PAT-1:0]         hit;
  logic                     flag;
  logic [CNT_W-1:0]         match_cnt;
`ifdef SEQ_DET_STICKY_EN
  logic [N_PAT-1:0]         sticky;
`endif

  modport master (
    output din, din_valid, cfg_load, pat_cfg, len_cfg, overlap_en, cnt_clr,
`ifdef SEQ_DET_STICKY_EN
    input  sticky,
`endif
    input  hit, flag, match_cnt
  );

  modport slave (
    input  din, din_valid, cfg_load, pat_cfg, len_cfg, overlap_en, cnt_clr,
`ifdef SEQ_DET_STICKY_EN
    output sticky,
`endif
    output hit, flag, match_cnt
  );
endinterface

// File: rtl/seq_detect_multi.sv
// seq_detect_multi: serial bit-stream detector with N_PAT runtime-programmable
// patterns of up to MAX_LEN bits each. A single shared history shift register
// feeds every slot. Each slot has a fill counter. The counter stops a match
// from being reported before len fresh bits have arrived.
// The outputs are a registered per-slot hit, the OR'd flag and a saturating
// match counter.
// Optional feature: SEQ_DET_STICKY_EN adds per-slot sticky bits. A sticky bit
// is set by a hit and cleared by cnt_clr. Set wins over clear.
module seq_detect_multi #(
  parameter int N_PAT   = 2,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_detect_multi_if.slave bus
);
  localparam int            LW      = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  logic [MAX_LEN-1:0]            hist_q, hist_d;
  logic [N_PAT-1:0][LW-1:0]      fill_q, fill_d;
  logic [N_PAT-1:0][MAX_LEN-1:0] pat_q, pat_d;
  logic [N_PAT-1:0][LW-1:0]      len_q, len_d;
  logic [N_PAT-1:0]              ovl_q, ovl_d;
  logic [N_PAT-1:0]              hit_q, hit_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [MAX_LEN-1:0]            window;
  logic [N_PAT-1:0]              match;
  logic [N_PAT-1:0][LW-1:0]      len_clamp;
  logic                          flag;

  // The newest bit joins the history at bit 0, so pattern bit 0 is the bit received last.
  assign window = {hist_q[MAX_LEN-2:0], bus.din};

  for (genvar gi = 0; gi < N_PAT; gi++) begin : g_slot
    logic [LW-1:0]      len_raw;
    logic [MAX_LEN-1:0] mask;
    logic [LW:0]        fill_inc;

    assign len_raw       = bus.len_cfg[gi*LW +: LW];
    assign len_clamp[gi] = (len_raw > LEN_MAX) ? LEN_MAX : len_raw;

    // Only the low len bits of the window take part in the comparison.
    always_comb begin
      mask = '0;
      for (int j = 0; j < MAX_LEN; j++) begin
        mask[j] = (j < int'(len_q[gi]));
      end
    end

    assign fill_inc  = {1'b0, fill_q[gi]} + {{LW{1'b0}}, 1'b1};
    assign match[gi] = bus.din_valid && (len_q[gi] != '0) &&
                       (fill_inc >= {1'b0, len_q[gi]}) &&
                       (((window ^ pat_q[gi]) & mask) == '0);
  end

  // Next state for the history, the fill counters, the configuration and the hit.
  // cfg_load flushes everything and discards the bit presented in the same cycle.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hit_d  = '0;
    if (bus.cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      pat_d  = bus.pat_cfg;
      len_d  = len_clamp;
      ovl_d  = bus.overlap_en;
    end else if (bus.din_valid) begin
      hist_d = window;
      hit_d  = match;
      for (int i = 0; i < N_PAT; i++) begin
        if (match[i] && !ovl_q[i]) begin
          fill_d[i] = '0;
        end else if (fill_q[i] != LEN_MAX) begin
          fill_d[i] = fill_q[i] + LW'(1);
        end
      end
    end
  end

  assign flag = |hit_q;

  // Match counter: one count per flagged cycle, holds at all-ones, and a clear wins.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (flag && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  // Reset disables every slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= '0;
      hit_q  <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hit_q  <= hit_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.hit       = hit_q;
  assign bus.flag      = flag;
  assign bus.match_cnt = cnt_q;

`ifdef SEQ_DET_STICKY_EN
  logic [N_PAT-1:0] sticky_q, sticky_d;

  // Sticky bits: set by a visible hit, cleared by cnt_clr, and set wins.
  always_comb begin
    sticky_d = hit_q | (bus.cnt_clr ? '0 : sticky_q);
  end

  // Sticky register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.sticky = sticky_q;
`endif
endmodule

// File: tb/tb_seq_detect_multi.sv
// tb_seq_detect_multi: table-driven bench for seq_detect_multi.
// Two instances share one stimulus stream. One has an 8-bit counter and the
// other a 2-bit counter, so saturation is visible.
// Expected results are queued as each vector is driven and are compared one
// edge later.
`timescale 1ns/1ps
module tb_seq_detect_multi;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_detect_multi_if #(.N_PAT(2), .MAX_LEN(8), .CNT_W(8)) bus8 ();
  seq_detect_multi_if #(.N_PAT(2), .MAX_LEN(8), .CNT_W(2)) bus2 ();

  seq_detect_multi #(.N_PAT(2), .MAX_LEN(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  seq_detect_multi #(.N_PAT(2), .MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  assign bus2.din        = bus8.din;
  assign bus2.din_valid  = bus8.din_valid;
  assign bus2.cfg_load   = bus8.cfg_load;
  assign bus2.pat_cfg    = bus8.pat_cfg;
  assign bus2.len_cfg    = bus8.len_cfg;
  assign bus2.overlap_en = bus8.overlap_en;
  assign bus2.cnt_clr    = bus8.cnt_clr;

  typedef struct {
    logic        rstn;
    logic        load;
    logic [15:0] pat;
    logic [7:0]  len;
    logic [1:0]  ovl;
    logic        vld;
    logic        d;
    logic        clr;
    logic [1:0]  hit;
  } vec_t;

  typedef struct {
    logic [1:0] hit;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [1:0] sticky;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  logic [15:0] cur_pat = '0;
  logic [7:0]  cur_len = '0;
  logic [1:0]  cur_ovl = '0;
  logic [1:0]  m_hit = '0;
  logic [7:0]  m_cnt8 = '0;
  logic [1:0]  m_cnt2 = '0;
  logic [1:0]  m_sticky = '0;

  function automatic void add(input logic rstn, input logic load, input logic vld,
                              input logic d, input logic clr, input logic [1:0] hit);
    vec_t v;
    v.rstn = rstn; v.load = load; v.pat = cur_pat; v.len = cur_len; v.ovl = cur_ovl;
    v.vld = vld; v.d = d; v.clr = clr; v.hit = hit;
    tv.push_back(v);
  endfunction

  function automatic void cfg(input logic [15:0] pat, input logic [7:0] len, input logic [1:0] ovl);
    cur_pat = pat; cur_len = len; cur_ovl = ovl;
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
  endfunction

  // s: '0'/'1' valid bits, '-' a gap with din=1; h: expected hit vector per position.
  function automatic void stream(input string s, input string h);
    for (int i = 0; i < s.len(); i++) begin
      logic [1:0] hv;
      hv = 2'(h[i] - 8'h30);
      add(1'b1, 1'b0, s[i] != "-", s[i] != "0", 1'b0, hv);
    end
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, step_no, act, exp);
    end
  endtask

  // Drive one vector, predict the state after the coming edge and queue it.
  task automatic apply(input vec_t v);
    exp_t e;
    if (!v.rstn) begin
      e.hit = '0; e.cnt8 = '0; e.cnt2 = '0; e.sticky = '0;
    end else begin
      e.hit = (v.load || !v.vld) ? 2'b00 : v.hit;
      if (v.clr) begin
        e.cnt8 = '0; e.cnt2 = '0;
      end else begin
        e.cnt8 = (|m_hit && m_cnt8 != 8'hFF) ? m_cnt8 + 8'd1 : m_cnt8;
        e.cnt2 = (|m_hit && m_cnt2 != 2'b11) ? m_cnt2 + 2'd1 : m_cnt2;
      end
      e.sticky = m_hit | (v.clr ? 2'b00 : m_sticky);
    end
    m_hit = e.hit; m_cnt8 = e.cnt8; m_cnt2 = e.cnt2; m_sticky = e.sticky;
    rst_n           = v.rstn;
    bus8.cfg_load   = v.load;
    bus8.pat_cfg    = v.pat;
    bus8.len_cfg    = v.len;
    bus8.overlap_en = v.ovl;
    bus8.din_valid  = v.vld;
    bus8.din        = v.d;
    bus8.cnt_clr    = v.clr;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_vectors();
    foreach (tv[i]) apply(tv[i]);
    tv.delete();
  endtask

  // Compare the DUT outputs against the oldest queued expectation just after each edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      step_no++;
      $display("step %0d hit=%b flag=%b cnt8=%0d cnt2=%0d", step_no,
               bus8.hit, bus8.flag, bus8.match_cnt, bus2.match_cnt);
      check("hit", 32'(bus8.hit), 32'(e.hit));
      check("flag", 32'(bus8.flag), 32'(|e.hit));
      check("match_cnt8", 32'(bus8.match_cnt), 32'(e.cnt8));
      check("match_cnt2", 32'(bus2.match_cnt), 32'(e.cnt2));
`ifdef SEQ_DET_STICKY_EN
      check("sticky", 32'(bus8.sticky), 32'(e.sticky));
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    bus8.cfg_load = 1'b0; bus8.pat_cfg = '0; bus8.len_cfg = '0; bus8.overlap_en = '0;
    bus8.din_valid = 1'b0; bus8.din = 1'b0; bus8.cnt_clr = 1'b0;

    // Reset state
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    idle(1);
    // Overlapping 1101, with a gap carrying din=1 that must be ignored
    cfg(16'h000D, 8'h04, 2'b01);
    stream("11-01101", "00001001");
    idle(2);
    // Non-overlapping 1101
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    cfg(16'h000D, 8'h04, 2'b00);
    stream("1101101", "0001000");
    idle(2);
    // Two slots hitting on different cycles, then on the same cycle
    cfg(16'h060D, 8'h44, 2'b11);
    stream("01101", "00021");
    idle(2);
    cfg(16'h0D0D, 8'h44, 2'b11);
    stream("1101", "0003");
    idle(2);
    // Saturation of the 2-bit counter, then a clear while flag is high
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    cfg(16'h000D, 8'h04, 2'b01);
    stream("1101101101101101101", "0001001001001001001");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    idle(2);
    // Slot1 disabled (len 0) with matching data; slot0 len 15 clamps to 8
    cfg(16'h06B5, 8'h0F, 2'b11);
    stream("10110101", "00000001");
    idle(2);
    run_vectors();

    // Flush by cfg_load mid-pattern; the bit in the load cycle is discarded
    cfg(16'h010D, 8'h44, 2'b11);
    stream("110", "000");
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    stream("1011101", "0000001");
    idle(1);
    // Reset mid-pattern discards the partial match and disables the slots
    stream("110", "000");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    stream("1", "0");
    cfg(16'h010D, 8'h44, 2'b11);
    stream("1101", "0001");
    idle(3);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    idle(2);
    run_vectors();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
